// File: rtl/muldiv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_pkg
// Shared definitions for the HI/LO multiply/divide sequencer:
//   - ALU opcodes reused from the core ALU (only ADD and SUB are issued)
//   - mul/div operation encodings (op[1] = signed, op[0] = divide)
//   - sequencer state encodings
//   - small decode helpers for the op field
// Build option: MULDIV_SIGNED_EN (see muldiv_ctrl.sv) enables the signed
// PRE/FIX states; the encodings below are always present.
// ---------------------------------------------------------------------------
package muldiv_ctrl_pkg;

    // Core ALU opcodes (same codes as the EX-stage ALU decoder).
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // Mul/div operation encodings.
    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_DIVU  = 2'b01;
    localparam logic [1:0] MD_MULT  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_ITERS = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_PRE_A  = 3'd2,
        ST_PRE_B  = 3'd3,
        ST_FIX_LO = 3'd4,
        ST_FIX_HI = 3'd5
    } md_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        case (op)
            MD_DIVU, MD_DIV: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        case (op)
            MD_MULT, MD_DIV: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
// Iterative HI/LO multiply/divide sequencer. Borrows the shared 32-bit ALU
// for one add/sub per cycle (shift-add multiply, restoring divide) and owns
// the architectural HI/LO registers.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   launch op (sampled only in IDLE)
//   op       in   [1:0] 00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   rs_val   in   [31:0] multiplicand / dividend
//   rt_val   in   [31:0] multiplier / divisor
//   abort    in   kill in-flight op
//   wr_hi    in   MTHI write (IDLE and start=0 only)
//   wr_lo    in   MTLO write (IDLE and start=0 only)
//   wr_data  in   [31:0] data for wr_hi/wr_lo
//   alu_out  in   [31:0] shared ALU result
//   alu_req  out  controller owns the ALU (== busy)
//   alu_a    out  [31:0] ALU operand A
//   alu_b    out  [31:0] ALU operand B
//   alu_op   out  [3:0]  ALU opcode (ALU_ADD / ALU_SUB)
//   busy     out  op in flight
//   done     out  one-cycle pulse, hi/lo hold the new result
//   hi       out  [31:0] architectural HI
//   lo       out  [31:0] architectural LO
//
// Build option: define MULDIV_SIGNED_EN to honour op[1] (signed MULT/DIV via
// PRE_A/PRE_B operand negation and FIX_LO/FIX_HI result correction).
// Without it, MULT/DIV run as MULTU/DIVU.
//
// Working registers (shared between mul and div):
//   acc_q  : P_hi (mul) / remainder R (div)
//   wrk_q  : P_lo, initially the multiplier (mul) / quotient Q, initially
//            the dividend (div)
//   opnd_q : multiplicand (mul) / divisor (div)
// ---------------------------------------------------------------------------
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        abort,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    input  logic [31:0] alu_out,
    output logic        alu_req,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] wrk_q, wrk_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

`ifdef MULDIV_SIGNED_EN
    logic        signed_q, signed_d;
    logic        neg_lo_q, neg_lo_d;    // negate LO (product / quotient)
    logic        neg_hi_q, neg_hi_d;    // negate HI (product / remainder)
    logic        lz_q, lz_d;            // magnitude LO was zero: carry into HI
`endif

    // One iteration of the shift-add / restoring-divide step.
    logic [31:0] r_sh;
    logic        take;
    logic        carry;
    logic [31:0] sum;
    logic [31:0] step_acc;
    logic [31:0] step_wrk;

    assign r_sh = {acc_q[30:0], wrk_q[31]};

    always_comb begin
        take     = 1'b0;
        carry    = 1'b0;
        sum      = acc_q;
        step_acc = acc_q;
        step_wrk = wrk_q;
        if (is_div_q) begin
            // acc_q[31] set means the 33-bit shifted remainder already
            // exceeds any 32-bit divisor.
            take     = acc_q[31] | (r_sh >= opnd_q);
            step_acc = take ? alu_out : r_sh;
            step_wrk = {wrk_q[30:0], take};
        end else begin
            if (wrk_q[0]) begin
                sum   = alu_out;
                carry = (alu_out < acc_q);
            end
            step_acc = {carry, sum[31:1]};
            step_wrk = {sum[0], wrk_q[31:1]};
        end
    end

    // ALU operand mux: combinational from state and working registers.
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = acc_q;
        alu_b  = opnd_q;
        if (is_div_q) begin
            alu_op = ALU_SUB;
            alu_a  = r_sh;
        end
`ifdef MULDIV_SIGNED_EN
        case (state_q)
            ST_PRE_A, ST_FIX_LO: begin
                alu_op = ALU_SUB;
                alu_a  = 32'd0;
                alu_b  = wrk_q;
            end
            ST_PRE_B: begin
                alu_op = ALU_SUB;
                alu_a  = 32'd0;
                alu_b  = opnd_q;
            end
            ST_FIX_HI: begin
                if (is_div_q) begin
                    alu_op = ALU_SUB;
                    alu_a  = 32'd0;
                    alu_b  = acc_q;
                end else begin
                    // Upper half of a 64-bit two's complement negate.
                    alu_op = ALU_ADD;
                    alu_a  = ~acc_q;
                    alu_b  = {31'd0, lz_q};
                end
            end
            default: ;
        endcase
`endif
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        acc_d    = acc_q;
        wrk_d    = wrk_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MULDIV_SIGNED_EN
        signed_d = signed_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        lz_d     = lz_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_div_d = op_is_div(op);
                    cnt_d    = 5'd0;
                    acc_d    = 32'd0;
                    if (op_is_div(op)) begin
                        wrk_d  = rs_val;
                        opnd_d = rt_val;
                    end else begin
                        wrk_d  = rt_val;
                        opnd_d = rs_val;
                    end
                    state_d = ST_RUN;
`ifdef MULDIV_SIGNED_EN
                    signed_d = op_is_signed(op);
                    neg_lo_d = rs_val[31] ^ rt_val[31];
                    // Remainder follows the dividend; product uses xor.
                    neg_hi_d = op_is_div(op) ? rs_val[31] : (rs_val[31] ^ rt_val[31]);
                    if (op_is_signed(op)) begin
                        state_d = ST_PRE_A;
                    end
`endif
                end else begin
                    if (wr_hi) hi_d = wr_data;
                    if (wr_lo) lo_d = wr_data;
                end
            end
            ST_RUN: begin
                acc_d = step_acc;
                wrk_d = step_wrk;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
`ifdef MULDIV_SIGNED_EN
                    if (signed_q) begin
                        state_d = ST_FIX_LO;
                    end else begin
                        state_d = ST_IDLE;
                        hi_d    = step_acc;
                        lo_d    = step_wrk;
                        done_d  = 1'b1;
                    end
`else
                    state_d = ST_IDLE;
                    hi_d    = step_acc;
                    lo_d    = step_wrk;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef MULDIV_SIGNED_EN
            ST_PRE_A: begin
                if (wrk_q[31]) wrk_d = alu_out;
                state_d = ST_PRE_B;
            end
            ST_PRE_B: begin
                if (opnd_q[31]) opnd_d = alu_out;
                state_d = ST_RUN;
            end
            ST_FIX_LO: begin
                lz_d = (wrk_q == 32'd0);
                if (neg_lo_q) wrk_d = alu_out;
                state_d = ST_FIX_HI;
            end
            ST_FIX_HI: begin
                if (neg_hi_q) acc_d = alu_out;
                hi_d    = neg_hi_q ? alu_out : acc_q;
                lo_d    = wrk_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // A flush kills the in-flight op; a start in IDLE is a new op.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            is_div_q <= 1'b0;
            acc_q    <= 32'd0;
            wrk_q    <= 32'd0;
            opnd_q   <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            acc_q    <= acc_d;
            wrk_q    <= wrk_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

`ifdef MULDIV_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signed_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            lz_q     <= 1'b0;
        end else begin
            signed_q <= signed_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            lz_q     <= lz_d;
        end
    end
`endif

    assign busy    = (state_q != ST_IDLE);
    assign alu_req = busy;
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_muldiv_ctrl
// Directed bench for muldiv_ctrl with a behavioural model of the shared ALU.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, so "cycle N" below means the cycle after the N-th edge from start.
// ---------------------------------------------------------------------------
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        abort = 1'b0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] alu_out;
    logic        alu_req;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Core ALU: only ADD and SUB matter here.
    always_comb begin
        alu_out = alu_a + alu_b;
        if (alu_op == ALU_SUB) alu_out = alu_a - alu_b;
    end

    muldiv_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .abort   (abort),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .alu_out (alu_out),
        .alu_req (alu_req),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

`ifdef MULDIV_SIGNED_EN
    localparam int SIGNED_LAT = 37;
`else
    localparam int SIGNED_LAT = 33;
`endif

    // Present an op for one cycle; returns in cycle 1 of that op.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op     = o;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    // Step until done (bounded). cyc = cycle index at which done was seen;
    // miss counts cycles where busy or alu_req was not asserted before done.
    task automatic wait_done(input int c0, output int cyc, output int miss);
        cyc  = c0;
        miss = 0;
        while (done !== 1'b1 && cyc < 80) begin
            if (busy !== 1'b1 || alu_req !== 1'b1) miss++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, alu_req} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got busy/done/req=%b expected 000", {busy, done, alu_req});
        end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_hilo: got hi=%h lo=%h expected 0/0", hi, lo);
        end
        checks++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== ALU_ADD) begin
            failures++;
            $display("FAIL reset_alu: got a=%h b=%h op=%h expected 0/0/%h", alu_a, alu_b, alu_op, ALU_ADD);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_multu;
        int cyc, miss;
        launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if (alu_req !== 1'b1 || alu_op !== ALU_ADD) begin
            failures++;
            $display("FAIL multu_alu_c1: got req=%b op=%h expected 1/%h", alu_req, alu_op, ALU_ADD);
        end
        wait_done(1, cyc, miss);
        checks++;
        if (cyc !== 33) begin
            failures++;
            $display("FAIL multu_latency: got done cycle %0d expected 33", cyc);
        end
        checks++;
        if (miss !== 0 || busy !== 1'b0 || alu_req !== 1'b0) begin
            failures++;
            $display("FAIL multu_busy: got gaps=%0d busy_at_done=%b expected 0/0", miss, busy);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            failures++;
            $display("FAIL multu_result: got hi=%h lo=%h expected fffffffe/00000001", hi, lo);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL multu_done_pulse: got done=%b expected 0", done);
        end
        $display("test_multu: hi=%h lo=%h cycle=%0d", hi, lo, cyc);
    endtask

    task automatic test_divu;
        int cyc, miss;
        launch(MD_DIVU, 32'd100, 32'd7);
        wait_done(1, cyc, miss);
        checks++;
        if (cyc !== 33 || lo !== 32'd14 || hi !== 32'd2) begin
            failures++;
            $display("FAIL divu_100_7: got cyc=%0d lo=%h hi=%h expected 33/e/2", cyc, lo, hi);
        end
        @(posedge clk);
        #1;
        launch(MD_DIVU, 32'hFFFF_FFFF, 32'h8000_0001);
        wait_done(1, cyc, miss);
        checks++;
        if (lo !== 32'd1 || hi !== 32'h7FFF_FFFE) begin
            failures++;
            $display("FAIL divu_big: got lo=%h hi=%h expected 1/7ffffffe", lo, hi);
        end
        @(posedge clk);
        #1;
        launch(MD_DIVU, 32'h1234, 32'd0);
        wait_done(1, cyc, miss);
        checks++;
        if (cyc !== 33 || lo !== 32'hFFFF_FFFF || hi !== 32'h1234) begin
            failures++;
            $display("FAIL divu_by_zero: got cyc=%0d lo=%h hi=%h expected 33/ffffffff/1234", cyc, lo, hi);
        end
        @(posedge clk);
        #1;
        $display("test_divu: last lo=%h hi=%h", lo, hi);
    endtask

    task automatic test_mthi_mtlo;
        int cyc, miss;
        wr_hi   = 1'b1;
        wr_data = 32'h55;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        checks++;
        if (hi !== 32'h55 || lo !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL mthi_idle: got hi=%h lo=%h expected 55/ffffffff", hi, lo);
        end
        // MTLO together with start is dropped; the op still runs.
        wr_lo   = 1'b1;
        wr_data = 32'h77;
        launch(MD_DIVU, 32'd100, 32'd7);
        wr_lo = 1'b0;
        checks++;
        if (busy !== 1'b1 || lo !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL mtlo_with_start: got busy=%b lo=%h expected 1/ffffffff", busy, lo);
        end
        // MTHI while busy is dropped as well.
        wr_hi   = 1'b1;
        wr_data = 32'h99;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        checks++;
        if (hi !== 32'h55) begin
            failures++;
            $display("FAIL mthi_busy: got hi=%h expected 55", hi);
        end
        wait_done(2, cyc, miss);
        checks++;
        if (cyc !== 33 || lo !== 32'd14 || hi !== 32'd2) begin
            failures++;
            $display("FAIL mtx_op_result: got cyc=%0d lo=%h hi=%h expected 33/e/2", cyc, lo, hi);
        end
        @(posedge clk);
        #1;
        $display("test_mthi_mtlo: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_abort;
        int cyc, miss, seen;
        wr_hi   = 1'b1;
        wr_data = 32'hA;
        @(posedge clk);
        #1;
        wr_hi   = 1'b0;
        wr_lo   = 1'b1;
        wr_data = 32'hB;
        @(posedge clk);
        #1;
        wr_lo = 1'b0;
        launch(MD_DIVU, 32'd1000, 32'd3);          // now cycle 1
        repeat (8) begin
            @(posedge clk);
            #1;
        end                                          // cycle 9
        start  = 1'b1;                               // ignored: busy
        op     = MD_MULTU;
        rs_val = 32'd5;
        rt_val = 32'd6;
        @(posedge clk);
        #1;                                          // cycle 10
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        #1;                                          // cycle 11
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'hA || lo !== 32'hB) begin
            failures++;
            $display("FAIL abort_idle: got busy=%b done=%b hi=%h lo=%h expected 0/0/a/b", busy, done, hi, lo);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0 || hi !== 32'hA || lo !== 32'hB) begin
            failures++;
            $display("FAIL abort_quiet: got activity=%0d hi=%h lo=%h expected 0/a/b", seen, hi, lo);
        end
        // abort in IDLE alongside start: start wins.
        abort = 1'b1;
        launch(MD_DIVU, 32'd100, 32'd7);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_start_idle: got busy=%b expected 1", busy);
        end
        wait_done(1, cyc, miss);
        checks++;
        if (cyc !== 33 || lo !== 32'd14 || hi !== 32'd2) begin
            failures++;
            $display("FAIL abort_start_result: got cyc=%0d lo=%h hi=%h expected 33/e/2", cyc, lo, hi);
        end
        @(posedge clk);
        #1;
        $display("test_abort: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_reset_mid;
        int cyc, miss;
        launch(MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || alu_req !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL midreset_state: got busy=%b req=%b done=%b hi=%h lo=%h expected 0/0/0/0/0",
                     busy, alu_req, done, hi, lo);
        end
        checks++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== ALU_ADD) begin
            failures++;
            $display("FAIL midreset_alu: got a=%h b=%h op=%h expected 0/0/%h", alu_a, alu_b, alu_op, ALU_ADD);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        launch(MD_MULTU, 32'd123, 32'd456);
        wait_done(1, cyc, miss);
        checks++;
        if (cyc !== 33 || hi !== 32'd0 || lo !== 32'd56088) begin
            failures++;
            $display("FAIL midreset_rerun: got cyc=%0d hi=%h lo=%h expected 33/0/db18", cyc, hi, lo);
        end
        @(posedge clk);
        #1;
        $display("test_reset_mid: lo=%h", lo);
    endtask

    task automatic test_signed;
        int cyc, miss;
        launch(MD_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(1, cyc, miss);
        checks++;
        if (cyc !== SIGNED_LAT || miss !== 0) begin
            failures++;
            $display("FAIL mult_latency: got cyc=%0d gaps=%0d expected %0d/0", cyc, miss, SIGNED_LAT);
        end
`ifdef MULDIV_SIGNED_EN
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            failures++;
            $display("FAIL mult_signed: got hi=%h lo=%h expected ffffffff/fffffff1", hi, lo);
        end
        @(posedge clk);
        #1;
        launch(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, cyc, miss);
        checks++;
        if (cyc !== 37 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL div_signed: got cyc=%0d lo=%h hi=%h expected 37/fffffffd/ffffffff", cyc, lo, hi);
        end
`else
        // Signed ops fall back to unsigned: (2^32-3)*5.
        checks++;
        if (hi !== 32'd4 || lo !== 32'hFFFF_FFF1) begin
            failures++;
            $display("FAIL mult_as_multu: got hi=%h lo=%h expected 4/fffffff1", hi, lo);
        end
        @(posedge clk);
        #1;
        launch(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, cyc, miss);
        checks++;
        if (cyc !== 33 || lo !== 32'h7FFF_FFFC || hi !== 32'd1) begin
            failures++;
            $display("FAIL div_as_divu: got cyc=%0d lo=%h hi=%h expected 33/7ffffffc/1", cyc, lo, hi);
        end
`endif
        @(posedge clk);
        #1;
        $display("test_signed: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_back_to_back;
        int cyc, miss;
        launch(MD_MULTU, 32'h0001_0000, 32'h0001_0000);
        wait_done(1, cyc, miss);
        checks++;
        if (cyc !== 33 || hi !== 32'd1 || lo !== 32'd0) begin
            failures++;
            $display("FAIL b2b_first: got cyc=%0d hi=%h lo=%h expected 33/1/0", cyc, hi, lo);
        end
        // Start in the done cycle itself.
        launch(MD_DIVU, 32'hFFFF_FFFF, 32'h10);
        wait_done(1, cyc, miss);
        checks++;
        if (cyc !== 33 || lo !== 32'h0FFF_FFFF || hi !== 32'hF) begin
            failures++;
            $display("FAIL b2b_second: got cyc=%0d lo=%h hi=%h expected 33/0fffffff/f", cyc, lo, hi);
        end
        @(posedge clk);
        #1;
        $display("test_back_to_back: lo=%h hi=%h", lo, hi);
    endtask

    initial begin
        test_reset();
        test_multu();
        test_divu();
        test_mthi_mtlo();
        test_abort();
        test_reset_mid();
        test_signed();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
